// File: rtl/game_pkg.sv
// Shared types and constants for the minesweeper board datapath.
// The board memory arbiter and the settings-bus arbiter both use these.
package game_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN  = 2'd1,
        ERR  = 2'd2
    } arb_state_t;

    localparam int MST_PLANTER = 0;
    localparam int MST_DEFUSER = 1;
    localparam int MST_VGA     = 2;

    localparam int BOARD_ADDR_W = 10;
    localparam int BOARD_DATA_W = 8;

    // An index into n items needs at least one bit, even when n is 1.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/board_wb_arbiter_rr_pick.sv
// Combinational round-robin selector: returns the first set request found
// searching upward from the slot after `last`, wrapping around.
module rr_pick
    import game_pkg::*;
#(
    parameter int N = 3
) (
    input  logic [N-1:0]          req,
    input  logic [idx_w(N)-1:0]   last,
    output logic [idx_w(N)-1:0]   winner,
    output logic                  valid
);

    localparam int W = idx_w(N);

    logic [2*N-1:0] dbl;
    logic [N-1:0]   rot;
    int             base;

    // Rotating a doubled copy puts slot (last+1) at bit 0, so a plain
    // lowest-bit-first scan gives round-robin order.
    always_comb begin
        base   = (int'(last) + 1) % N;
        dbl    = {req, req} >> base;
        rot    = dbl[N-1:0];
        winner = '0;
        valid  = 1'b0;
        for (int j = 0; j < N; j++) begin
            if (!valid && rot[j]) begin
                valid  = 1'b1;
                winner = W'((base + j) % N);
            end
        end
    end

endmodule

// File: rtl/board_wb_arbiter.sv
// Round-robin Wishbone arbiter for the game-board memory: an owner keeps the
// bus for its whole cyc so RMW is atomic, and a stalled slave yields m_err.
module board_wb_arbiter
    import game_pkg::*;
#(
    parameter int N_MST   = 3,
    parameter int ADDR_W  = BOARD_ADDR_W,
    parameter int DATA_W  = BOARD_DATA_W,
    parameter int TIMEOUT = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_MST-1:0]           m_cyc,
    input  logic [N_MST-1:0]           m_stb,
    input  logic [N_MST-1:0]           m_we,
    input  logic [N_MST*ADDR_W-1:0]    m_adr,
    input  logic [N_MST*DATA_W-1:0]    m_dat_w,
    output logic [DATA_W-1:0]          m_dat_r,
    output logic [N_MST-1:0]           m_ack,
    output logic [N_MST-1:0]           m_err,
    output logic                       s_cyc,
    output logic                       s_stb,
    output logic                       s_we,
    output logic [ADDR_W-1:0]          s_adr,
    output logic [DATA_W-1:0]          s_dat_w,
    input  logic [DATA_W-1:0]          s_dat_r,
    input  logic                       s_ack,
    output logic [idx_w(N_MST)-1:0]    owner,
    output logic                       busy
);

    localparam int OWN_W = idx_w(N_MST);
    localparam int CNT_W = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    arb_state_t       state_q, state_d;
    logic [OWN_W-1:0] owner_q, owner_d;
    logic [OWN_W-1:0] last_q, last_d;
    logic [OWN_W-1:0] pick_win;
    logic             pick_vld;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [ADDR_W-1:0] adr_a [N_MST];
    logic [DATA_W-1:0] dat_a [N_MST];
    logic              own_cyc, own_stb, own_we, timeout_hit;

    always_comb begin
        for (int i = 0; i < N_MST; i++) begin
            adr_a[i] = m_adr[i*ADDR_W +: ADDR_W];
            dat_a[i] = m_dat_w[i*DATA_W +: DATA_W];
        end
    end

    rr_pick #(.N(N_MST)) u_pick (
        .req    (m_cyc),
        .last   (last_q),
        .winner (pick_win),
        .valid  (pick_vld)
    );

    // A strobe without cyc is not a live transfer, so it never times out.
    assign own_cyc     = m_cyc[owner_q];
    assign own_stb     = own_cyc & m_stb[owner_q];
    assign own_we      = m_we[owner_q];
    assign timeout_hit = (state_q == OWN) && own_stb && !s_ack && (cnt_q == CNT_LAST);

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        unique case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    owner_d = pick_win;
                    state_d = OWN;
                end
            end
            OWN: begin
                if (!own_cyc) begin
                    last_d  = owner_q;
                    state_d = IDLE;
                end else if (timeout_hit) begin
                    state_d = ERR;
                end
            end
            ERR: begin
                if (!own_cyc) begin
                    last_d  = owner_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // An ack in the final stalled cycle beats the timeout.
    assign cnt_d = ((state_q == OWN) && own_stb && !s_ack && !timeout_hit) ? cnt_q + 1'b1 : '0;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            owner_q <= '0;
            last_q  <= OWN_W'(N_MST - 1);
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    // Outputs are gated by rst so that reset silences the bus immediately.
    always_comb begin
        s_cyc   = 1'b0;
        s_stb   = 1'b0;
        s_we    = 1'b0;
        s_adr   = '0;
        s_dat_w = '0;
        m_ack   = '0;
        m_err   = '0;
        busy    = 1'b0;
        if (rst) begin
            if (state_q == OWN) begin
                busy           = 1'b1;
                s_cyc          = own_cyc;
                s_stb          = own_stb;
                s_we           = own_we;
                s_adr          = adr_a[owner_q];
                s_dat_w        = dat_a[owner_q];
                m_ack[owner_q] = s_ack;
                m_err[owner_q] = timeout_hit;
            end else if (state_q == ERR) begin
                busy = 1'b1;
            end
        end
    end

    assign m_dat_r = s_dat_r;
    assign owner   = owner_q;

endmodule

// File: tb/tb_board_wb_arbiter.sv
// Scoreboarded bench for board_wb_arbiter: directed master/slave sequences
// queue expected responses; a negedge monitor checks every ack/err.
module tb_board_wb_arbiter;

    localparam int N  = 3;
    localparam int AW = 10;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  m_cyc, m_stb, m_we;
    logic [N*AW-1:0] m_adr;
    logic [N*DW-1:0] m_dat_w;
    logic [DW-1:0] m_dat_r;
    logic [N-1:0]  m_ack, m_err;
    logic          s_cyc, s_stb, s_we;
    logic [AW-1:0] s_adr;
    logic [DW-1:0] s_dat_w, s_dat_r;
    logic          s_ack;
    logic [1:0]    owner;
    logic          busy;

    always #5 clk = ~clk;

    board_wb_arbiter #(.N_MST(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(16)) dut (
        .clk(clk), .rst(rst),
        .m_cyc(m_cyc), .m_stb(m_stb), .m_we(m_we), .m_adr(m_adr), .m_dat_w(m_dat_w),
        .m_dat_r(m_dat_r), .m_ack(m_ack), .m_err(m_err),
        .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_adr(s_adr), .s_dat_w(s_dat_w),
        .s_dat_r(s_dat_r), .s_ack(s_ack), .owner(owner), .busy(busy)
    );

    typedef struct {
        logic [N-1:0]  ack;
        logic [N-1:0]  err;
        logic [AW-1:0] adr;
        logic          we;
        logic [DW-1:0] wdat;
        logic [DW-1:0] rdat;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    exp_t tmp_e;
    int   nchk = 0;
    int   nerr = 0;
    int   rr_i;
    int   to_n;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        nchk++;
        if (act !== want) begin
            nerr++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [N-1:0] ack, input logic [N-1:0] err, input logic [AW-1:0] adr,
                        input logic we, input logic [DW-1:0] wdat, input logic [DW-1:0] rdat);
        tmp_e.ack  = ack;
        tmp_e.err  = err;
        tmp_e.adr  = adr;
        tmp_e.we   = we;
        tmp_e.wdat = wdat;
        tmp_e.rdat = rdat;
        exp_q.push_back(tmp_e);
    endtask

    // Owner i strobes one transfer; the slave inserts one wait state then acks.
    task automatic do_xfer(input int i, input logic we, input logic [AW-1:0] adr,
                           input logic [DW-1:0] wdat, input logic [DW-1:0] rdat);
        m_stb[i] = 1'b1;
        m_we[i]  = we;
        m_adr[i*AW +: AW]   = adr;
        m_dat_w[i*DW +: DW] = wdat;
        push(3'b001 << i, '0, adr, we, wdat, rdat);
        tick();
        s_ack   = 1'b1;
        s_dat_r = rdat;
        tick();
        s_ack   = 1'b0;
        s_dat_r = '0;
        m_stb[i] = 1'b0;
    endtask

    // From the negedge of a quiet IDLE cycle: raise requests, expect one
    // cycle of arbitration latency, then the grant.
    task automatic request(input logic [N-1:0] mask, input int want_owner, input string name);
        tick();
        m_cyc = m_cyc | mask;
        @(negedge clk);
        chk({name, "_latency"}, s_cyc, 0);
        tick();
        @(negedge clk);
        chk({name, "_owner"}, owner, want_owner);
        chk({name, "_cyc"}, s_cyc, 1);
        tick();
    endtask

    task automatic release_bus(input int i, input string name);
        m_cyc[i] = 1'b0;
        m_stb[i] = 1'b0;
        @(negedge clk);
        chk({name, "_scyc"}, s_cyc, 0);
        tick();
        @(negedge clk);
        chk({name, "_idle"}, busy, 0);
    endtask

    always @(negedge clk) begin
        if (rst === 1'b1 && (m_ack != '0 || m_err != '0)) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_resp", {m_ack, m_err}, 0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("sb_ack", m_ack, mon_e.ack);
                chk("sb_err", m_err, mon_e.err);
                chk("sb_adr", s_adr, mon_e.adr);
                chk("sb_we", s_we, mon_e.we);
                if (mon_e.err == '0) begin
                    if (mon_e.we) chk("sb_wdat", s_dat_w, mon_e.wdat);
                    else          chk("sb_rdat", m_dat_r, mon_e.rdat);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", nchk);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst     = 1'b0;
        m_cyc   = '1;
        m_stb   = '1;
        m_we    = '1;
        m_adr   = {3{10'h155}};
        m_dat_w = '1;
        s_ack   = 1'b1;
        s_dat_r = 8'h5A;

        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("reset_quiet", {s_cyc, s_stb, s_we, s_adr, s_dat_w, m_ack, m_err, busy}, 0);
        end
        tick();
        rst     = 1'b1;
        m_stb   = '0;
        m_we    = '0;
        s_ack   = 1'b0;
        s_dat_r = '0;
        @(negedge clk);
        chk("reset_latency", s_cyc, 0);
        @(negedge clk);
        chk("reset_owner", owner, 0);
        chk("reset_grant_cyc", s_cyc, 1);

        // Round robin 0,1,2,0 with all three requesting.
        for (int k = 0; k < 4; k++) begin
            rr_i = k % 3;
            tick();
            do_xfer(rr_i, 1'b1, 10'h100 + 10'(k), 8'h10 + 8'(k), 8'h00);
            release_bus(rr_i, "rr_release");
            if (k == 0) m_cyc[0] = 1'b1;
            tick();
            @(negedge clk);
            if (k < 3) begin
                chk("rr_owner", owner, (k + 1) % 3);
                chk("rr_cyc", s_cyc, 1);
            end else begin
                chk("rr_done_idle", busy, 0);
            end
        end

        // Atomic read-modify-write by the defuser while VGA waits.
        m_adr[2*AW +: AW] = 10'h3AA;
        request(3'b110, 1, "rmw_grant");
        do_xfer(1, 1'b0, 10'h005, 8'h00, 8'h20);
        @(negedge clk);
        chk("rmw_hold_owner", owner, 1);
        chk("rmw_hold_adr", s_adr, 10'h005);
        tick();
        do_xfer(1, 1'b1, 10'h005, 8'h21, 8'h00);
        release_bus(1, "rmw_release");
        tick();
        @(negedge clk);
        chk("vga_owner", owner, 2);
        chk("vga_cyc", s_cyc, 1);
        tick();
        do_xfer(2, 1'b0, 10'h3FF, 8'h00, 8'hA5);
        release_bus(2, "vga_release");

        // Planter stalls: the slave never acks.
        request(3'b001, 0, "to_grant");
        m_stb[0] = 1'b1;
        m_we[0]  = 1'b0;
        m_adr[0 +: AW] = 10'h010;
        push('0, 3'b001, 10'h010, 1'b0, 8'h00, 8'h00);
        to_n = 0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (m_err[0]) begin
                to_n = n;
                break;
            end
            tick();
        end
        chk("timeout_cycles", to_n, 16);
        tick();
        s_ack = 1'b1;
        @(negedge clk);
        chk("err_quiet", {s_cyc, s_stb, m_ack}, 0);
        chk("err_busy", busy, 1);
        tick();
        s_ack = 1'b0;
        @(negedge clk);
        chk("err_single_pulse", m_err, 0);
        chk("err_hold", busy, 1);
        tick();
        release_bus(0, "err_release");

        // Ack arrives on the 16th stalled cycle and must win.
        request(3'b010, 1, "race_grant");
        m_stb[1] = 1'b1;
        m_we[1]  = 1'b1;
        m_adr[1*AW +: AW]   = 10'h033;
        m_dat_w[1*DW +: DW] = 8'h44;
        push(3'b010, '0, 10'h033, 1'b1, 8'h44, 8'h00);
        repeat (15) tick();
        s_ack = 1'b1;
        @(negedge clk);
        chk("race_ack", m_ack, 3'b010);
        chk("race_no_err", m_err, 0);
        tick();
        s_ack = 1'b0;
        m_stb[1] = 1'b0;
        release_bus(1, "race_release");

        // VGA abandons a stalled strobe on its 16th cycle: abort, no error.
        request(3'b100, 2, "abort_grant");
        m_stb[2] = 1'b1;
        m_we[2]  = 1'b0;
        m_adr[2*AW +: AW] = 10'h2A0;
        repeat (15) tick();
        m_cyc[2] = 1'b0;
        @(negedge clk);
        chk("abort_no_err", m_err, 0);
        chk("abort_scyc", s_cyc, 0);
        tick();
        m_stb[2] = 1'b0;
        @(negedge clk);
        chk("abort_idle", busy, 0);

        // A lone requester wins again right after its own release.
        request(3'b100, 2, "rereq_grant");
        release_bus(2, "rereq_release");

        chk("sb_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule

// File: doc/board_wb_arbiter.md
Name: board_wb_arbiter

Overview:
- Round-robin Wishbone arbiter that shares the single game-board memory slave port among N masters: mine planter, defuser and VGA reader.
- Sits between the masters and the board memory in the 100 MHz domain.
- Holds bus ownership for a whole cycle (cyc held high) so read-modify-write sequences are atomic.
- Adds a per-transfer ack timeout so a stalled slave cannot lock up the game.

Parameters:
- N_MST, 3, number of masters; index 0 = planter, 1 = defuser, 2 = vga.
- ADDR_W, 10, board address width.
- DATA_W, 8, board cell data width.
- TIMEOUT, 16, cycles a strobe may wait for ack before an error is returned (≥2).

Ports:
- clk  in  1  system clock (100 MHz).
- rst  in  1  synchronous, active-low reset.
- m_cyc  in  N_MST  per-master cycle request.
- m_stb  in  N_MST  per-master strobe.
- m_we  in  N_MST  per-master write enable.
- m_adr  in  N_MST*ADDR_W  packed addresses; master i occupies [i*ADDR_W +: ADDR_W].
- m_dat_w  in  N_MST*DATA_W  packed write data.
- m_dat_r  out  DATA_W  read data, broadcast to all masters.
- m_ack  out  N_MST  per-master ack.
- m_err  out  N_MST  per-master timeout error pulse.
- s_cyc, s_stb, s_we  out  1  slave cycle, strobe and write enable.
- s_adr  out  ADDR_W  slave address.
- s_dat_w  out  DATA_W  slave write data.
- s_dat_r  in  DATA_W  slave read data.
- s_ack  in  1  slave ack.
- owner  out  $clog2(N_MST)  current owner index.
- busy  out  1  high while the bus is owned.

Behaviour:
- Reset (rst==0 at a clk edge):
  - state=IDLE, owner=0, last=N_MST-1, timeout counter=0.
  - All s_* outputs 0; m_ack=0; m_err=0; busy=0.
  - Reset mid-transfer aborts immediately; any pending s_ack is ignored.
- State IDLE:
  - Outputs: s_cyc=0, s_stb=0, busy=0.
  - If any m_cyc is set, pick the first requester searching from (last+1) mod N_MST upward, with wrap-around.
  - Register owner=winner and go to OWN. Arbitration latency is 1 cycle; the slave sees cyc on the cycle after the request is first sampled.
- State OWN:
  - busy=1. s_cyc = m_cyc[owner]; s_stb, s_we, s_adr, s_dat_w are combinationally muxed from the owner.
  - m_ack[owner] = s_ack, and m_ack of every other master is 0. m_dat_r = s_dat_r.
  - Non-owners' requests are ignored; they wait.
  - When m_cyc[owner] falls: last=owner, go to IDLE. There is one idle cycle between owners, which is mandatory.
- Timeout:
  - The counter increments in OWN while s_stb=1 and s_ack=0, and clears on s_ack or when stb is low.
  - When the counter reaches TIMEOUT-1 with no ack: m_err[owner]=1 for exactly 1 cycle, then go to ERR.
- State ERR:
  - s_cyc=0, s_stb=0, busy=1, m_ack all 0.
  - Wait until m_cyc[owner]=0, then set last=owner and go to IDLE.
  - A late s_ack arriving in ERR is dropped.
- Boundary conditions:
  - Simultaneous requests: round-robin order only; no fixed priority.
  - A single requester re-requesting right after release wins again after the 1 idle cycle.
  - s_ack arriving in the same cycle the counter hits TIMEOUT-1: the ack wins, so no error is raised.
  - Owner drops cyc while stb is high with no ack: treated as an abort, go to IDLE, no error.
  - N_MST=1 must degenerate cleanly, with owner width forced to ≥1.

Decomposition:
- Put the following in the shared package (game_pkg):
  - arb_state_t enum {IDLE, OWN, ERR}.
  - Master index constants MST_PLANTER=0, MST_DEFUSER=1, MST_VGA=2.
  - BOARD_ADDR_W and BOARD_DATA_W defaults.
- One sub-module: rr_pick.
  - Combinational round-robin selector.
  - Inputs: req vector, last index. Outputs: winner index, valid.
  - Reusable by the settings-bus arbiter.
- The FSM, output mux and timeout counter stay in board_wb_arbiter.

Test Plan:
- Reset: hold rst=0 for 3 cycles while all m_cyc=1 → all s_*=0, m_ack=0, busy=0. Release reset → owner=0 and s_cyc=1 one cycle later (last was 2).
- Round-robin: m_cyc=3'b111, each master does one write and drops cyc after its ack → grants in order 0,1,2,0, each separated by one idle cycle.
- Atomic RMW: defuser holds cyc across a read of adr 0x05 then a write of 0x21; VGA requests throughout → VGA is granted only after defuser cyc falls. s_adr never shows a VGA address mid-cycle.
- Timeout: planter strobes adr 0x10 and the slave never acks → m_err[0]=1 exactly once, 16 cycles after the stb. s_cyc=0 afterwards; IDLE is reached after planter drops cyc.
- Ack/timeout race: s_ack asserted on the 16th stalled cycle → m_ack[owner]=1, m_err=0.
- Read data: VGA reads adr 0x3FF and the slave returns 0xA5 with ack → m_dat_r=0xA5 and m_ack=3'b100 in the same cycle.
